con_pixel_feed: RTL

Pixel-stream feeder that sits directly upstream of the line-buffered convolution core. It reads a raster image, one 16-bit pixel per word, from a synchronous image RAM. It presents each pixel on `din` with a one-cycle `i_en` strobe at a fixed pacing interval, then flags completion. It replaces the ad-hoc address/pacing logic previously kept in benches, so the convolution core can be driven identically in simulation and on hardware.

---
 rtl/con_pixel_feed.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/con_pixel_feed.sv
// Pixel-stream feeder: paces raster reads from a synchronous image RAM into the convolution core.
// Optional end-of-line flag enabled by defining CON_FEED_EOL_EN.
module con_pixel_feed #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NPIX   = 262144,
    parameter int unsigned PACE   = 16,
    parameter int unsigned LINE_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] din,
    output logic              i_en,
    output logic              busy,
    output logic              done
`ifdef CON_FEED_EOL_EN
    ,
    output logic              eol
`endif
);

    localparam int unsigned PACE_W = (PACE > 1) ? $clog2(PACE) : 1;
    localparam int unsigned LINE_CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(PACE - 1);
    localparam logic [PACE_W-1:0] PACE_RD   = PACE_W'(PACE - 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    // Elaboration-time sanity check on the configuration.
    if (PACE < 2 || NPIX < 1 || LINE_W < 1 || DATA_W < 1) begin : g_param_err
        $error("con_pixel_feed: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PACE_W-1:0]   r_pace;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd_pend;
    logic [DATA_W-1:0]   r_din;
    logic                r_i_en;
    logic                r_busy;
    logic                r_done;
    logic                w_mem_rd;
    logic                w_run_entry;
    logic                w_frame_end;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and read-issue decode.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_rd    = 1'b0;
        w_run_entry = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_run_entry = 1'b1;
                end
            end
            S_RUN: begin
                w_mem_rd = (r_pace == PACE_RD) && !hold;
                if (w_mem_rd && (r_addr == LAST_ADDR)) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // The only strobe seen in FLUSH belongs to the final pixel.
                if (r_i_en) begin
                    w_state_nxt = S_DONE;
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pacing counter, frozen outside RUN and while held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pace <= '0;
        end else if (w_run_entry) begin
            r_pace <= '0;
        end else if ((r_state == S_RUN) && !hold) begin
            r_pace <= (r_pace == PACE_LAST) ? '0 : r_pace + PACE_W'(1);
        end
    end

    // Read address; parks on the last pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (w_run_entry) begin
            r_addr <= '0;
        end else if (w_mem_rd && (r_addr != LAST_ADDR)) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // Capture of issued reads is independent of hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_pend <= 1'b0;
            r_din     <= '0;
            r_i_en    <= 1'b0;
        end else begin
            r_rd_pend <= w_mem_rd;
            r_i_en    <= r_rd_pend;
            if (r_rd_pend) begin
                r_din <= mem_data;
            end
        end
    end

    // Frame status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (w_run_entry) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (w_frame_end) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
        end
    end

`ifdef CON_FEED_EOL_EN
    localparam logic [LINE_CW-1:0] LINE_LAST = LINE_CW'(LINE_W - 1);

    logic [LINE_CW-1:0] r_line;
    logic               r_eol;

    // Line position of the pixel currently being captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line <= '0;
            r_eol  <= 1'b0;
        end else begin
            r_eol <= r_rd_pend && ((r_line == LINE_LAST) || (r_state == S_FLUSH));
            if (w_run_entry) begin
                r_line <= '0;
            end else if (r_rd_pend) begin
                r_line <= (r_line == LINE_LAST) ? '0 : r_line + LINE_CW'(1);
            end
        end
    end

    assign eol = r_eol;
`else
    localparam int unsigned LINE_UNUSED = LINE_CW;
    if (LINE_UNUSED == 0) begin : g_line_err
        $error("con_pixel_feed: bad line width");
    end
`endif

    assign mem_addr = r_addr;
    assign mem_rd   = w_mem_rd;
    assign din      = r_din;
    assign i_en     = r_i_en;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
